// File: rtl/ps2_key_event_controller_if.sv
// Bus between the scan-code sequencer and its neighbours: the raw byte input
// from the PS/2 receiver and the CPU-side event queue port.
interface ps2_key_event_controller_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    scanCode;
  logic          scanCodeReady;
  logic          eventRead;
  logic          overflowClear;
  logic          eventValid;
  logic [12:0]   eventData;
  logic [CW-1:0] fifoCount;
  logic [2:0]    modifiers;
  logic          overflow;

  // Driver side: the receiver and the CPU.
  modport master (
    output scanCode, scanCodeReady, eventRead, overflowClear,
    input  eventValid, eventData, fifoCount, modifiers, overflow
  );

  // The sequencer itself.
  modport slave (
    input  scanCode, scanCodeReady, eventRead, overflowClear,
    output eventValid, eventData, fifoCount, modifiers, overflow
  );
endinterface

// File: rtl/ps2_key_event_controller.sv
// Set-2 scan-code sequencer: resolves E0/F0/E1 prefixes, tracks modifier keys
// and queues one 13-bit key event per keystroke in a first-word-fall-through
// FIFO popped by the CPU.
module ps2_key_event_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input logic                       clk,
  input logic                       rst,
  ps2_key_event_controller_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        r_state;
  logic [2:0]    r_skip;
  logic [TW-1:0] r_tmo;
  logic          r_ready_prev;

  logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;

  logic [12:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_byte_stb;
  logic [7:0]    w_byte;
  logic          w_is_e0, w_is_f0, w_is_e1, w_filt;
  logic          w_push, w_ext, w_rel;
  logic [7:0]    w_code;
  logic w_lshift_n, w_rshift_n, w_lctrl_n, w_rctrl_n, w_lalt_n, w_ralt_n;
  logic [12:0]   w_event;
  logic          w_full, w_empty, w_pop, w_wr_en, w_ovf_set;

  assign w_byte     = bus.scanCode;
  assign w_byte_stb = bus.scanCodeReady & ~r_ready_prev;
  assign w_is_e0    = (w_byte == 8'hE0);
  assign w_is_f0    = (w_byte == 8'hF0);
  assign w_is_e1    = (w_byte == 8'hE1);
  // Self-test, ack, resend, echo and error bytes never describe a key.
  assign w_filt     = (w_byte == 8'hAA) || (w_byte == 8'hFA) || (w_byte == 8'hFE) ||
                      (w_byte == 8'hEE) || (w_byte == 8'h00) || (w_byte == 8'hFF);

  // Decide whether this byte completes a keystroke and what it describes.
  always_comb begin
    w_push = 1'b0;
    w_ext  = 1'b0;
    w_rel  = 1'b0;
    w_code = w_byte;
    if (w_byte_stb) begin
      case (r_state)
        S_IDLE:    w_push = ~(w_is_e0 | w_is_f0 | w_is_e1 | w_filt);
        S_EXT: begin
          w_push = ~(w_is_e0 | w_is_f0 | w_is_e1 | w_filt);
          w_ext  = 1'b1;
        end
        S_BRK: begin
          w_push = ~(w_is_e0 | w_is_f0);
          w_rel  = 1'b1;
        end
        S_EXT_BRK: begin
          w_push = ~(w_is_e0 | w_is_f0);
          w_ext  = 1'b1;
          w_rel  = 1'b1;
        end
        S_PAUSE: begin
          // The whole 8-byte pause sequence collapses into one E1 event.
          w_push = (r_skip == 3'd1);
          w_code = 8'hE1;
        end
        default: w_push = 1'b0;
      endcase
    end
  end

  // Next modifier state, so the event carries the state after this byte.
  always_comb begin
    w_lshift_n = r_lshift;
    w_rshift_n = r_rshift;
    w_lctrl_n  = r_lctrl;
    w_rctrl_n  = r_rctrl;
    w_lalt_n   = r_lalt;
    w_ralt_n   = r_ralt;
    if (w_push) begin
      if (!w_ext && w_code == 8'h12) w_lshift_n = ~w_rel;
      if (!w_ext && w_code == 8'h59) w_rshift_n = ~w_rel;
      if (!w_ext && w_code == 8'h14) w_lctrl_n  = ~w_rel;
      if ( w_ext && w_code == 8'h14) w_rctrl_n  = ~w_rel;
      if (!w_ext && w_code == 8'h11) w_lalt_n   = ~w_rel;
      if ( w_ext && w_code == 8'h11) w_ralt_n   = ~w_rel;
    end
  end

  assign w_event = {w_lalt_n | w_ralt_n, w_lctrl_n | w_rctrl_n, w_lshift_n | w_rshift_n,
                    w_ext, w_rel, w_code};

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = bus.eventRead & ~w_empty;
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // Edge detector; starts high so a level held through reset is not a byte.
  always_ff @(posedge clk) begin
    if (rst) r_ready_prev <= 1'b1;
    else     r_ready_prev <= bus.scanCodeReady;
  end

  // Prefix-sequence FSM with abandon timer for stalled sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_skip  <= 3'd0;
      r_tmo   <= '0;
    end else if (w_byte_stb) begin
      r_tmo <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_is_e0)      r_state <= S_EXT;
          else if (w_is_f0) r_state <= S_BRK;
          else if (w_is_e1) begin
            r_state <= S_PAUSE;
            r_skip  <= 3'd7;
          end
        end
        S_EXT: begin
          if (w_is_f0)      r_state <= S_EXT_BRK;
          else if (!w_is_e0) r_state <= S_IDLE;
        end
        S_PAUSE: begin
          r_skip <= r_skip - 3'd1;
          if (r_skip == 3'd1) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_tmo == TMO_LAST) begin
        r_state <= S_IDLE;
        r_tmo   <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  // Modifier key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_lctrl  <= 1'b0;
      r_rctrl  <= 1'b0;
      r_lalt   <= 1'b0;
      r_ralt   <= 1'b0;
    end else begin
      r_lshift <= w_lshift_n;
      r_rshift <= w_rshift_n;
      r_lctrl  <= w_lctrl_n;
      r_rctrl  <= w_rctrl_n;
      r_lalt   <= w_lalt_n;
      r_ralt   <= w_ralt_n;
    end
  end

  // Event FIFO storage; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_event;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - CW'(1);
      r_overflow <= w_ovf_set | (r_overflow & ~bus.overflowClear);
    end
  end

  assign bus.eventValid = ~w_empty;
  assign bus.eventData  = w_empty ? 13'h0 : r_mem[r_rd_ptr];
  assign bus.fifoCount  = r_count;
  assign bus.modifiers  = {r_lalt | r_ralt, r_lctrl | r_rctrl, r_lshift | r_rshift};
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_controller.sv
// Bench for the PS/2 key event sequencer: directed keystroke scenarios with
// literal expectations, then randomized byte streams against a queue model.
module tb_ps2_key_event_controller;
  localparam int DEPTH = 4;
  localparam int PT    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_event_controller_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_key_event_controller #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(PT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [12:0] q[$];
  bit m_prev = 1'b1;
  bit m_ext, m_brk, m_ovf;
  int m_pause, m_since;
  bit held[6];  // lShift rShift lCtrl rCtrl lAlt rAlt

  function automatic logic [2:0] mods();
    return {held[4] | held[5], held[2] | held[3], held[0] | held[1]};
  endfunction

  function automatic int mod_idx(bit ext, logic [7:0] b);
    if (!ext && b == 8'h12) return 0;
    if (!ext && b == 8'h59) return 1;
    if (!ext && b == 8'h14) return 2;
    if ( ext && b == 8'h14) return 3;
    if (!ext && b == 8'h11) return 4;
    if ( ext && b == 8'h11) return 5;
    return -1;
  endfunction

  task automatic abandon();
    m_ext = 0; m_brk = 0; m_pause = 0; m_since = 0;
  endtask

  task automatic key(input logic [7:0] b, input bit ext, input bit rel,
                     output bit have, output logic [12:0] ev);
    int idx;
    idx = mod_idx(ext, b);
    if (idx >= 0) held[idx] = !rel;
    ev = {mods(), ext, rel, b};
    have = 1;
  endtask

  task automatic decode(input logic [7:0] b, output bit have, output logic [12:0] ev);
    bit filt;
    filt = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) ||
           (b == 8'h00) || (b == 8'hFF);
    have = 0; ev = '0; m_since = 0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin have = 1; ev = {mods(), 2'b00, 8'hE1}; end
      return;
    end
    if (m_brk) begin
      if (!(b == 8'hF0 || b == 8'hE0)) key(b, m_ext, 1, have, ev);
      abandon();
      return;
    end
    if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        if (!(filt || b == 8'hE1)) key(b, 1, 0, have, ev);
        abandon();
      end
      return;
    end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_pause = 7;
    else if (!filt) key(b, 0, 0, have, ev);
  endtask

  task automatic model_step();
    bit stb, pop, have, setv;
    logic [12:0] ev;
    int pre;
    if (rst) begin
      q.delete(); m_prev = 1; abandon(); m_ovf = 0;
      foreach (held[i]) held[i] = 0;
      return;
    end
    stb = bus.scanCodeReady && !m_prev;
    m_prev = bus.scanCodeReady;
    have = 0; ev = '0;
    if (stb) decode(bus.scanCode, have, ev);
    else if (m_ext || m_brk || m_pause > 0) begin
      m_since++;
      if (m_since >= PT) abandon();
    end
    pre = q.size();
    pop = bus.eventRead && pre > 0;
    if (pop) void'(q.pop_front());
    setv = 0;
    if (have) begin
      if (pre < DEPTH || pop) q.push_back(ev);
      else setv = 1;
    end
    m_ovf = setv || (m_ovf && !bus.overflowClear);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [12:0] exp_d;
    @(posedge clk);
    #1;
    exp_d = (q.size() > 0) ? q[0] : 13'h0;
    chk("eventValid", bus.eventValid, q.size() > 0);
    chk("eventData",  bus.eventData, exp_d);
    chk("fifoCount",  bus.fifoCount, q.size());
    chk("modifiers",  bus.modifiers, mods());
    chk("overflow",   bus.overflow, m_ovf);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    if (rnd) begin
      bus.eventRead     = ($urandom_range(0, 3) == 0);
      bus.overflowClear = ($urandom_range(0, 15) == 0);
    end else begin
      bus.eventRead     = 1'b0;
      bus.overflowClear = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int hold = 1, input int gap = 2);
    bus.scanCode = b;
    bus.scanCodeReady = 1'b1;
    repeat (hold) step();
    bus.scanCodeReady = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pop();
    bus.eventRead = 1'b1;
    @(negedge clk);
    bus.eventRead = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (bus.eventValid && guard < 2 * DEPTH) begin pop(); guard++; end
    chk("drain empties", bus.eventValid, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, bus.eventValid, 0);
    chk({tag, " data"},  bus.eventData, 0);
    chk({tag, " count"}, bus.fifoCount, 0);
    chk({tag, " mods"},  bus.modifiers, 0);
    chk({tag, " ovf"},   bus.overflow, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [16];
    pool = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h14, 8'h11, 8'h75,
             8'h6B, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00};
    bus.scanCode = 8'h00;
    bus.scanCodeReady = 1'b1;   // held high through reset: not a byte
    bus.eventRead = 1'b0;
    bus.overflowClear = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    bus.scanCodeReady = 1'b0;
    step();

    // Make/break A
    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("A count", bus.fifoCount, 2);
    chk("A make", bus.eventData, 13'h01C);
    pop();
    chk("A break", bus.eventData, 13'h11C);
    pop();
    chk("A empty", bus.eventValid, 0);

    // Shifted extended key
    send(8'h12);
    chk("shift mods", bus.modifiers, 3'b001);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("shift held", bus.modifiers, 3'b001);
    send(8'hF0); send(8'h12);
    chk("shift released", bus.modifiers, 3'b000);
    chk("shift ev0", bus.eventData, 13'h412); pop();
    chk("shift ev1", bus.eventData, 13'h675); pop();
    chk("shift ev2", bus.eventData, 13'h775); pop();
    chk("shift ev3", bus.eventData, 13'h112); pop();
    chk("shift empty", bus.eventValid, 0);

    // Left vs right ctrl
    send(8'h14); send(8'hE0); send(8'h14); send(8'hF0); send(8'h14);
    chk("rctrl still held", bus.modifiers, 3'b010);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("ctrl released", bus.modifiers, 3'b000);
    drain();

    // Overflow
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    chk("ovf count", bus.fifoCount, 4);
    chk("ovf flag", bus.overflow, 1);
    chk("ovf head", bus.eventData, 13'h01C);
    bus.overflowClear = 1'b1; @(negedge clk); bus.overflowClear = 1'b0;
    chk("ovf cleared", bus.overflow, 0);
    bus.scanCode = 8'h2B; bus.scanCodeReady = 1'b1; bus.eventRead = 1'b1;
    @(negedge clk);
    bus.scanCodeReady = 1'b0; bus.eventRead = 1'b0;
    step();
    chk("full push+pop count", bus.fifoCount, 4);
    chk("full push+pop ovf", bus.overflow, 0);
    chk("full push+pop head", bus.eventData, 13'h032);
    drain();

    // Pause and filtering
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause count", bus.fifoCount, 1);
    chk("pause event", bus.eventData, 13'h0E1);
    drain();
    send(8'hAA); send(8'hFA);
    chk("filter count", bus.fifoCount, 0);

    // Prefix timeout
    send(8'hE0, 1, PT + 5);
    send(8'h1C);
    chk("timeout event", bus.eventData, 13'h01C);
    drain();

    // Reset mid-sequence
    send(8'h1C); send(8'h32); send(8'hE0); send(8'hF0);
    chk("pre-reset count", bus.fifoCount, 2);
    rst = 1'b1; step(); rst = 1'b0; step();
    chk_all_zero("midreset");
    send(8'h1C);
    chk("post-reset event", bus.eventData, 13'h01C);
    chk("post-reset count", bus.fifoCount, 1);
    drain();

    // Randomized byte streams
    rnd = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] b;
      int gap;
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(45, 60) : $urandom_range(1, 8);
      send(b, $urandom_range(1, 3), gap);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
    end
    rnd = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_controller.md
# ps2_key_event_controller

Sequencer between the PS2Keyboard receiver and the CPU-visible keyboard port. Consumes raw set-2 scan codes (`scanCode`/`scanCodeReady`) and resolves the 0xE0 (extended), 0xF0 (break) and 0xE1 (pause) prefix sequences. Tracks the shift, ctrl and alt modifiers, and queues one decoded key event per keystroke in a small first-word-fall-through FIFO that the CPU pops with a read strobe.

## Interface
- `FIFO_DEPTH`, default 4: event queue depth; must be a power of 2, at least 2.
- `PREFIX_TIMEOUT`, default 1000000: clk cycles allowed between a prefix byte and its following byte before the sequence is abandoned.
- `clk` in, 1: system clock; the only clock.
- `rst` in, 1: synchronous, active-high reset.
- `scanCode` in, 8: byte from PS2Keyboard; valid while `scanCodeReady` is high.
- `scanCodeReady` in, 1: new-byte indication; only its rising edge is used, so a pulse or a held level are both accepted.
- `eventRead` in, 1: pop the head event; ignored when the FIFO is empty.
- `overflowClear` in, 1: clears `overflow`.
- `eventValid` out, 1: the FIFO is non-empty.
- `eventData` out, 13: head event {alt[12], ctrl[11], shift[10], extended[9], release[8], code[7:0]}.
- `fifoCount` out, $clog2(FIFO_DEPTH)+1: number of queued events.
- `modifiers` out, 3: live {alt, ctrl, shift}.
- `overflow` out, 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Byte strobe: `byteStb = scanCodeReady & ~readyPrev`. `readyPrev` is a register and resets to 1, so a level held high through reset is not taken as a byte.
- FSM states: IDLE, EXT (saw E0), BRK (saw F0), EXT_BRK (saw E0 F0), PAUSE (skipping E1 tail). All transitions below happen only on `byteStb`.
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE, skip count = 7; AA/FA/FE/EE/00/FF -> dropped, stay; any other byte -> make event, stay.
  - EXT: F0 -> EXT_BRK; E0 -> stay; E1/AA/FA/FE/EE/00/FF -> drop, go to IDLE; any other byte -> extended make event, go to IDLE.
  - BRK: F0 or E0 -> IDLE, byte dropped (malformed); any other byte -> release event, go to IDLE.
  - EXT_BRK: F0 or E0 -> IDLE, dropped; any other byte -> extended release event, go to IDLE.
  - PAUSE: decrement the skip count on each byte. Reaching 0 pushes one event, code=E1, extended=0, release=0, and returns to IDLE.
- Prefix timeout: in EXT, BRK or EXT_BRK, a cycle counter starts at the prefix byte. If it reaches PREFIX_TIMEOUT with no byte, the FSM returns to IDLE and no event is produced. PAUSE times out the same way.
- Modifier registers are lShift, rShift, lCtrl, rCtrl, lAlt, rAlt. Codes:
  - 12 = lShift, 59 = rShift, 14 = lCtrl, E0 14 = rCtrl, 11 = lAlt, E0 11 = rAlt.
  - A make sets the register, a release clears it.
  - shift = lShift|rShift; ctrl = lCtrl|rCtrl; alt = lAlt|rAlt.
  - Each event carries the modifier state after that byte is applied; modifier keys generate events too.
- FIFO:
  - Push on event generation; pop on `eventRead` with `eventValid`.
  - Full with push and no pop: the event is dropped and `overflow` is set.
  - Full with push and pop in the same cycle: both take effect; count unchanged, no overflow.
  - Empty with push and pop: the pop is ignored and the push is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- `overflowClear` and a new overflow in the same cycle: `overflow` stays 1.

## Timing
- Reset values: all outputs 0, FSM in IDLE, modifiers cleared, FIFO empty, timeout counter 0.
- Latency: if `byteStb` is true at clock edge N, then at edge N+1:
  - `eventValid`, `eventData` and `fifoCount` reflect the push;
  - `modifiers` reflects the updated state.
- Pop: when `eventRead` is high at edge N, the next head (or `eventValid`=0) is visible after edge N. Back-to-back pops are allowed every cycle.
- `eventData` is stable while `eventValid`=1 and no pop occurs, including during pushes.
- `rst` mid-sequence (for example after E0 F0) discards the partial sequence and all queued events. The next byte is decoded from IDLE.
- The input rate is at most one byte per about 11 PS/2 bit times, far below the internal one-byte-per-cycle capability. A `byteStb` is never lost.

## Test plan
- Make/break "A": bytes 1C, F0 1C -> two events 0x01C then 0x11C; `fifoCount` goes to 2; two pops empty the queue and `eventValid`=0.
- Shifted extended key: bytes 12, E0 75, E0 F0 75, F0 12 -> events 0x412, 0x675, 0x775, 0x112; `modifiers` = 3'b001 between the first and last events, 3'b000 after.
- Right ctrl vs left ctrl: bytes 14, E0 14, F0 14 -> `modifiers[1]` stays 1 after the F0 14 because rCtrl is still held; after E0 F0 14 it goes to 0.
- Overflow: with FIFO_DEPTH=4, push 5 make codes with no reads -> `fifoCount`=4, `overflow`=1, head=first code. Then `overflowClear` -> `overflow`=0. A push and pop in the same cycle while full -> count stays 4, `overflow` stays 0.
- Pause and filtering: bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event, 0x0E1. Bytes AA and FA -> no events.
- Timeout and reset: E0, then PREFIX_TIMEOUT idle cycles, then 1C -> event 0x01C with extended=0. Separately, assert `rst` after E0 F0 with 2 events queued -> everything reads 0; a following 1C -> 0x01C.
